// File: rtl/cell_mem_ctrl.sv
// Cell memory controller. It streams every particle position of one cell out of a
// single-port RAM (the particle count is stored at address 0) and fits host writes in around the streams.
module cell_mem_ctrl #(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_start,
  output logic                  rd_busy,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] rd_index,
  output logic                  rd_last,
  output logic                  rd_done,
  output logic                  cnt_err,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CNT_RD   = 3'd1;
  localparam logic [2:0] CNT_WAIT = 3'd2;
  localparam logic [2:0] STREAM   = 3'd3;
  localparam logic [2:0] DRAIN    = 3'd4;
  localparam logic [2:0] WR       = 3'd5;

  localparam logic [ADDR_WIDTH-1:0] MAX_IDX = ADDR_WIDTH'(PARTICLE_NUM - 1);

  logic [2:0]            state;
  logic                  wait_cnt;
  logic                  rd_pend;
  logic [ADDR_WIDTH-1:0] count;
  logic [ADDR_WIDTH-1:0] issue_addr;

  // Read-return pipeline. Stage 0 lines up with mem_rden, and its index is mem_address.
  logic                  p0_valid;
  logic                  p0_last;
  logic                  p1_valid;
  logic                  p1_last;
  logic [ADDR_WIDTH-1:0] p1_idx;

  logic [ADDR_WIDTH-1:0] raw_cnt;
  logic                  cnt_over;
  logic [ADDR_WIDTH-1:0] cnt_clamped;
  logic                  first_beat;
  logic [ADDR_WIDTH-1:0] stream_len;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  accept;

  // The count word arrives on mem_q in the first STREAM cycle, and that cycle uses it directly.
  assign raw_cnt     = mem_q[ADDR_WIDTH-1:0];
  assign cnt_over    = raw_cnt > MAX_IDX;
  assign cnt_clamped = cnt_over ? MAX_IDX : raw_cnt;
  assign first_beat  = (issue_addr == '0);
  assign stream_len  = first_beat ? cnt_clamped : count;
  assign next_addr   = issue_addr + 1'b1;
  assign accept      = (state == IDLE) && (rd_start || rd_pend);

  // Gated so stale RAM output never shows while no beat is presented (e.g. in reset).
  assign rd_data = rd_valid ? mem_q : '0;

  // NOTE: every register here updates with non-blocking assignments. The next-state
  // logic then always reads values from before the edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= 1'b0;
      rd_pend     <= 1'b0;
      count       <= '0;
      issue_addr  <= '0;
      cnt_err     <= 1'b0;
      rd_busy     <= 1'b0;
      rd_done     <= 1'b0;
      wr_ack      <= 1'b0;
      mem_address <= '0;
      mem_data    <= '0;
      mem_rden    <= 1'b0;
      mem_wren    <= 1'b0;
      p0_valid    <= 1'b0;
      p0_last     <= 1'b0;
      p1_valid    <= 1'b0;
      p1_last     <= 1'b0;
      p1_idx      <= '0;
      rd_valid    <= 1'b0;
      rd_last     <= 1'b0;
      rd_index    <= '0;
    end else begin
      mem_rden <= 1'b0;
      mem_wren <= 1'b0;
      wr_ack   <= 1'b0;
      rd_done  <= 1'b0;
      p0_valid <= 1'b0;
      p0_last  <= 1'b0;

      // A second request while one is already pending is dropped.
      if (accept)
        rd_pend <= 1'b0;
      else if (rd_start && state != IDLE)
        rd_pend <= 1'b1;

      if (accept)
        rd_busy <= 1'b1;
      else if (rd_done)
        rd_busy <= 1'b0;

      case (state)
        IDLE: begin
          if (rd_start || rd_pend) begin
            state <= CNT_RD;
          end else if (wr_req) begin
            state       <= WR;
            mem_wren    <= 1'b1;
            mem_address <= wr_addr;
            mem_data    <= wr_data;
            wr_ack      <= 1'b1;
          end
        end

        CNT_RD: begin
          mem_rden    <= 1'b1;
          mem_address <= '0;
          issue_addr  <= '0;
          wait_cnt    <= 1'b0;
          state       <= CNT_WAIT;
        end

        CNT_WAIT: begin
          if (wait_cnt) state <= STREAM;
          else          wait_cnt <= 1'b1;
        end

        STREAM: begin
          if (first_beat) begin
            count <= cnt_clamped;
            if (cnt_over) cnt_err <= 1'b1;
          end
          if (stream_len == '0) begin
            rd_done <= 1'b1;
            state   <= IDLE;
          end else begin
            mem_rden    <= 1'b1;
            mem_address <= next_addr;
            issue_addr  <= next_addr;
            p0_valid    <= 1'b1;
            p0_last     <= (next_addr == stream_len);
            if (next_addr == stream_len) begin
              wait_cnt <= 1'b0;
              state    <= DRAIN;
            end
          end
        end

        DRAIN: begin
          if (wait_cnt) state <= IDLE;
          else          wait_cnt <= 1'b1;
        end

        WR: state <= IDLE;

        default: state <= IDLE;
      endcase

      // The RAM returns data two cycles after mem_rden. Beat flags and the index follow it down the pipe.
      p1_valid <= p0_valid;
      p1_last  <= p0_last;
      p1_idx   <= mem_address;
      rd_valid <= p1_valid;
      rd_last  <= p1_last;
      rd_index <= p1_idx;
      if (p1_last) rd_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cell_mem_ctrl.sv
// Bench for cell_mem_ctrl. It uses a two-cycle-latency RAM model and a reference that
// derives each stream's expected beats from the intended memory contents.
module tb_cell_mem_ctrl;
  localparam int DW   = 96;
  localparam int AW   = 8;
  localparam int PN   = 220;
  localparam int MAXN = PN - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_start;
  logic          rd_busy, rd_valid, rd_last, rd_done, cnt_err;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] rd_index;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data;
  logic          mem_rden, mem_wren;
  logic [DW-1:0] mem_q;

  always #5 clk = ~clk;

  cell_mem_ctrl dut (
    .clk(clk), .rst(rst), .rd_start(rd_start), .rd_busy(rd_busy),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_index(rd_index),
    .rd_last(rd_last), .rd_done(rd_done), .cnt_err(cnt_err),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .mem_address(mem_address), .mem_data(mem_data), .mem_rden(mem_rden),
    .mem_wren(mem_wren), .mem_q(mem_q)
  );

  // RAM environment: read data appears two cycles after the mem_rden cycle. Cycles with no read return junk.
  logic [DW-1:0] ram [0:PN-1];
  logic [DW-1:0] q_stage;
  always @(posedge clk) begin
    if (mem_wren && int'(mem_address) < PN) ram[mem_address] <= mem_data;
    q_stage <= (mem_rden && int'(mem_address) < PN) ? ram[mem_address] : {3{32'hDEAD_BEEF}};
    mem_q   <= q_stage;
  end

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
  } beat_t;

  logic [DW-1:0] model_mem [0:PN-1];
  beat_t beat_q[$];
  beat_t exp_q[$];
  int    done_cnt = 0;
  int    last_cnt = 0;
  int    viol     = 0;
  int    tests    = 0;
  int    fails    = 0;

  always @(negedge clk) begin
    beat_t b;
    if (rd_valid === 1'b1) begin
      b.idx  = rd_index;
      b.data = rd_data;
      beat_q.push_back(b);
    end
    if (rd_last === 1'b1) last_cnt++;
    if (rd_done === 1'b1) done_cnt++;
    if (mem_rden === 1'b1 && mem_wren === 1'b1) viol++;
    if (wr_ack === 1'b1 && rd_busy === 1'b1) viol++;
    if (wr_ack !== mem_wren) viol++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  task automatic preload(input int addr, input logic [DW-1:0] d);
    ram[addr]       = d;
    model_mem[addr] = d;
  endtask

  // Reference: a stream yields the words at addresses 1..min(count, PN-1) in order.
  function automatic void build_expected();
    int    n;
    beat_t b;
    exp_q.delete();
    n = int'(model_mem[0][AW-1:0]);
    if (n > MAXN) n = MAXN;
    for (int i = 1; i <= n; i++) begin
      b.idx  = AW'(i);
      b.data = model_mem[i];
      exp_q.push_back(b);
    end
  endfunction

  function automatic int first_bad();
    if (beat_q.size() != exp_q.size()) return -2;
    for (int i = 0; i < beat_q.size(); i++)
      if (beat_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic do_stream(input int budget, output bit timed_out);
    int d0;
    d0 = done_cnt;
    beat_q.delete();
    build_expected();
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (done_cnt > d0) begin
        timed_out = 1'b0;
        break;
      end
    end
    step();
  endtask

  task automatic do_write(input int addr, input logic [DW-1:0] d, output bit timed_out);
    wr_req    = 1'b1;
    wr_addr   = AW'(addr);
    wr_data   = d;
    timed_out = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (wr_ack === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
    end
    wr_req = 1'b0;
    model_mem[addr] = d;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; rd_start = 1'b1; wr_req = 1'b1; wr_addr = 8'd7; wr_data = rand_word();
    step(); step();
    tests++;
    if ({rd_busy, rd_valid, rd_last, rd_done, cnt_err, wr_ack, mem_rden, mem_wren} !== 8'h00 ||
        mem_address !== '0 || mem_data !== '0 || rd_data !== '0 || rd_index !== '0) begin
      fails++;
      $display("FAIL reset_hold: flags=%b addr=%0d data=%h", {rd_busy, rd_valid, rd_last, rd_done,
               cnt_err, wr_ack, mem_rden, mem_wren}, mem_address, mem_data);
    end
    rst = 1'b0; rd_start = 1'b0; wr_req = 1'b0;
    step();
    tests++;
    if ({rd_busy, rd_valid, rd_done, wr_ack, mem_rden, mem_wren} !== 6'h00 || mem_address !== '0) begin
      fails++;
      $display("FAIL reset_after: flags=%b addr=%0d expected all 0",
               {rd_busy, rd_valid, rd_done, wr_ack, mem_rden, mem_wren}, mem_address);
    end
    step();
  endtask

  task automatic test_basic_stream();
    logic [DW-1:0] w;
    w = rand_word();
    w[AW-1:0] = 8'd3;
    preload(0, w);
    for (int i = 1; i <= 3; i++) preload(i, rand_word());
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    for (int k = 0; k <= 9; k++) begin
      bit            e_rden, e_valid, e_end, e_busy;
      logic [AW-1:0] e_addr;
      if (k > 0) step();
      e_rden  = (k == 1) || (k >= 4 && k <= 6);
      e_addr  = (k == 1) ? '0 : AW'(k - 3);
      e_valid = (k >= 6 && k <= 8);
      e_end   = (k == 8);
      e_busy  = (k <= 8);
      tests++;
      if (mem_rden !== e_rden || (e_rden && mem_address !== e_addr) || mem_wren !== 1'b0) begin
        fails++;
        $display("FAIL basic_issue t+%0d: rden=%b addr=%0d, expected rden=%b addr=%0d",
                 k, mem_rden, mem_address, e_rden, e_addr);
      end
      tests++;
      if (rd_valid !== e_valid ||
          (e_valid && (rd_index !== AW'(k - 5) || rd_data !== model_mem[k - 5]))) begin
        fails++;
        $display("FAIL basic_beat t+%0d: valid=%b idx=%0d, expected valid=%b idx=%0d",
                 k, rd_valid, rd_index, e_valid, k - 5);
      end
      tests++;
      if (rd_last !== e_end || rd_done !== e_end || rd_busy !== e_busy) begin
        fails++;
        $display("FAIL basic_ctrl t+%0d: last=%b done=%b busy=%b, expected %b %b %b",
                 k, rd_last, rd_done, rd_busy, e_end, e_end, e_busy);
      end
    end
  endtask

  task automatic test_zero_count();
    logic [DW-1:0] w;
    int            n_valid;
    w = rand_word();
    w[AW-1:0] = 8'd0;
    preload(0, w);
    n_valid  = 0;
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) step();
      if (rd_valid === 1'b1 || rd_last === 1'b1) n_valid++;
      tests++;
      if (rd_done !== (k == 4) || rd_busy !== (k <= 4) || mem_rden !== (k == 1)) begin
        fails++;
        $display("FAIL zero_ctrl t+%0d: done=%b busy=%b rden=%b, expected %b %b %b",
                 k, rd_done, rd_busy, mem_rden, k == 4, k <= 4, k == 1);
      end
    end
    tests++;
    if (n_valid != 0) begin
      fails++;
      $display("FAIL zero_beats: %0d beats, expected 0", n_valid);
    end
  endtask

  task automatic test_write_priority();
    logic [DW-1:0] w, wd;
    int            d0, bad;
    bit            acked, to;
    w = rand_word();
    w[AW-1:0] = 8'd6;
    preload(0, w);
    for (int i = 1; i <= 6; i++) preload(i, rand_word());
    wd = rand_word();
    d0 = done_cnt;
    beat_q.delete();
    build_expected();
    acked = 1'b0;
    wr_req = 1'b1; wr_addr = 8'd5; wr_data = wd; rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (wr_ack === 1'b1) begin
        acked = 1'b1;
        tests++;
        if (done_cnt != d0 + 1) begin
          fails++;
          $display("FAIL wrprio_order: wr_ack with %0d streams done, expected 1", done_cnt - d0);
        end
        tests++;
        if (mem_wren !== 1'b1 || mem_address !== 8'd5 || mem_data !== wd) begin
          fails++;
          $display("FAIL wrprio_issue: wren=%b addr=%0d data=%h, expected 1 5 %h",
                   mem_wren, mem_address, mem_data, wd);
        end
        break;
      end
    end
    wr_req = 1'b0;
    tests++;
    if (!acked) begin
      fails++;
      $display("FAIL wrprio_ack: no wr_ack within 60 cycles");
    end
    bad = first_bad();
    tests++;
    if (bad != -1) begin
      fails++;
      $display("FAIL wrprio_stream1: beats=%0d expected=%0d first_bad=%0d", beat_q.size(), exp_q.size(), bad);
    end
    model_mem[5] = wd;
    step();
    do_stream(60, to);
    bad = first_bad();
    tests++;
    if (to || bad != -1) begin
      fails++;
      $display("FAIL wrprio_readback: timeout=%b first_bad=%0d idx5=%h expected %h",
               to, bad, (beat_q.size() > 4) ? beat_q[4].data : '0, wd);
    end
  endtask

  task automatic test_pending();
    logic [DW-1:0] w;
    int            d0;
    w = rand_word();
    w[AW-1:0] = 8'd4;
    preload(0, w);
    for (int i = 1; i <= 4; i++) preload(i, rand_word());
    build_expected();
    d0 = done_cnt;
    beat_q.delete();
    rd_start = 1'b1; step(); rd_start = 1'b0;
    step(); step();
    rd_start = 1'b1; step(); rd_start = 1'b0;
    step(); step();
    rd_start = 1'b1; step(); rd_start = 1'b0;
    repeat (60) step();
    tests++;
    if (done_cnt - d0 != 2) begin
      fails++;
      $display("FAIL pend_streams: %0d streams, expected 2", done_cnt - d0);
    end
    tests++;
    if (beat_q.size() != 8 || beat_q[0:3] != exp_q || beat_q[4:7] != exp_q) begin
      fails++;
      $display("FAIL pend_beats: %0d beats, expected 8 (two copies of 4)", beat_q.size());
    end
    tests++;
    if (rd_busy !== 1'b0) begin
      fails++;
      $display("FAIL pend_idle: rd_busy=%b expected 0", rd_busy);
    end
  endtask

  task automatic test_clamp();
    logic [DW-1:0] w;
    int            l0, bad;
    bit            to;
    w = rand_word();
    w[AW-1:0] = 8'd250;
    preload(0, w);
    for (int i = 1; i < PN; i++) preload(i, rand_word());
    l0 = last_cnt;
    do_stream(400, to);
    bad = first_bad();
    tests++;
    if (to || bad != -1) begin
      fails++;
      $display("FAIL clamp_beats: timeout=%b beats=%0d expected=%0d first_bad=%0d",
               to, beat_q.size(), MAXN, bad);
    end
    tests++;
    if (beat_q.size() == 0 || beat_q[beat_q.size()-1].idx !== AW'(MAXN) || last_cnt - l0 != 1) begin
      fails++;
      $display("FAIL clamp_last: last idx=%0d last pulses=%0d, expected %0d and 1",
               (beat_q.size() > 0) ? beat_q[beat_q.size()-1].idx : '0, last_cnt - l0, MAXN);
    end
    tests++;
    if (cnt_err !== 1'b1) begin
      fails++;
      $display("FAIL clamp_err: cnt_err=%b expected 1", cnt_err);
    end
    w[AW-1:0] = 8'd2;
    preload(0, w);
    do_stream(40, to);
    tests++;
    if (to || cnt_err !== 1'b1 || first_bad() != -1) begin
      fails++;
      $display("FAIL clamp_sticky: timeout=%b cnt_err=%b expected 1", to, cnt_err);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] w;
    int            stray;
    bit            to;
    w = rand_word();
    w[AW-1:0] = 8'd20;
    preload(0, w);
    rd_start = 1'b1; step(); rd_start = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    step();
    tests++;
    if ({rd_busy, rd_valid, rd_done, rd_last, mem_rden, cnt_err} !== 6'h00 || rd_data !== '0) begin
      fails++;
      $display("FAIL rstmid_clear: busy/valid/done/last/rden/err=%b expected 000000",
               {rd_busy, rd_valid, rd_done, rd_last, mem_rden, cnt_err});
    end
    rst = 1'b0;
    stray = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (rd_valid !== 1'b0 || rd_done !== 1'b0 || mem_rden !== 1'b0) stray++;
    end
    tests++;
    if (stray != 0) begin
      fails++;
      $display("FAIL rstmid_quiet: %0d cycles with activity after reset, expected 0", stray);
    end
    w[AW-1:0] = 8'd2;
    preload(0, w);
    do_stream(40, to);
    tests++;
    if (to || first_bad() != -1) begin
      fails++;
      $display("FAIL rstmid_restart: timeout=%b beats=%0d expected 2", to, beat_q.size());
    end
  endtask

  task automatic test_random();
    bit exp_err;
    bit to;
    exp_err = cnt_err;
    for (int it = 0; it < 6; it++) begin
      logic [DW-1:0] w;
      int            n, bad;
      n = $urandom_range(240);
      w = rand_word();
      w[AW-1:0] = AW'(n);
      do_write(0, w, to);
      for (int j = 0; j < 3; j++) begin
        bit t2;
        do_write($urandom_range(MAXN, 1), rand_word(), t2);
        to = to | t2;
      end
      if (n > MAXN) exp_err = 1'b1;
      tests++;
      if (to) begin
        fails++;
        $display("FAIL rand_write it%0d: wr_ack timeout", it);
      end
      do_stream(500, to);
      bad = first_bad();
      tests++;
      if (to || bad != -1) begin
        fails++;
        $display("FAIL rand_stream it%0d count=%0d: timeout=%b beats=%0d expected=%0d first_bad=%0d",
                 it, n, to, beat_q.size(), exp_q.size(), bad);
      end
      tests++;
      if (cnt_err !== exp_err) begin
        fails++;
        $display("FAIL rand_err it%0d: cnt_err=%b expected %b", it, cnt_err, exp_err);
      end
    end
  endtask

  task automatic test_invariants();
    tests++;
    if (viol != 0) begin
      fails++;
      $display("FAIL invariants: %0d cycles with rden&wren, wr_ack while busy, or wr_ack!=wren", viol);
    end
  endtask

  initial begin
    rst = 1'b1; rd_start = 1'b0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < PN; i++) preload(i, rand_word());
    test_reset();
    test_basic_stream();
    test_zero_count();
    test_write_priority();
    test_pending();
    test_clamp();
    test_reset_mid();
    test_random();
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cell_mem_ctrl.md
CELL_MEM_CTRL -- requirements
Module: cell_mem_ctrl

Interface
REQ-001 DATA_WIDTH, 96, width of one memory word {posz, posy, posx}; the count word at address 0 uses the same width.
REQ-002 ADDR_WIDTH, 8, cell memory address width.
REQ-003 PARTICLE_NUM, 220, number of memory words; the largest valid particle address is PARTICLE_NUM-1.
REQ-004 clk  in  1  single clock; all logic is rising-edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 rd_start  in  1  one-cycle pulse requesting a stream of the whole cell.
REQ-007 rd_busy  out  1  high from stream acceptance through the rd_done cycle.
REQ-008 rd_valid  out  1  rd_data holds one particle position this cycle.
REQ-009 rd_data  out  DATA_WIDTH  particle position, passed directly from mem_q.
REQ-010 rd_index  out  ADDR_WIDTH  memory address of the particle presented on rd_data.
REQ-011 rd_last  out  1  marks the final rd_valid beat of a stream.
REQ-012 rd_done  out  1  one-cycle pulse when a stream completes, including a zero-particle stream.
REQ-013 cnt_err  out  1  sticky flag: the stored particle count exceeded PARTICLE_NUM-1.
REQ-014 wr_req  in  1  write request; held high until acknowledged.
REQ-015 wr_addr  in  ADDR_WIDTH  write address; address 0 updates the particle count.
REQ-016 wr_data  in  DATA_WIDTH  write data.
REQ-017 wr_ack  out  1  one-cycle pulse in the same cycle the write is issued to memory.
REQ-018 mem_address / mem_data / mem_rden / mem_wren  out  ADDR_WIDTH / DATA_WIDTH / 1 / 1  drive the single-port cell RAM; all are registered.
REQ-019 mem_q  in  DATA_WIDTH  RAM read data, valid 2 cycles after the cycle in which mem_rden is high.

Function
REQ-020 The FSM SHALL have exactly these states: IDLE, CNT_RD (issue address 0), CNT_WAIT (2 cycles), STREAM, DRAIN (2 cycles), WR.
REQ-021 IDLE arbitration, in priority order: a pending or current rd_start goes to CNT_RD; otherwise wr_req goes to WR; otherwise stay in IDLE.
REQ-022 A rd_start arriving while not in IDLE SHALL set rd_pend; a second rd_start while rd_pend is set SHALL be dropped; rd_pend clears when the pending stream is accepted.
REQ-023 WR SHALL last one cycle: mem_wren=1, mem_address=wr_addr, mem_data=wr_data, wr_ack=1; the FSM then returns to IDLE.
REQ-024 While the FSM is not in WR, mem_wren SHALL be 0; mem_rden and mem_wren SHALL never both be 1.
REQ-025 Stream timing, with rd_start sampled at edge t:
- t+1: mem_rden=1, mem_address=0 (CNT_RD).
- t+3: count = mem_q[ADDR_WIDTH-1:0] is captured.
- t+4 onward: addresses 1..count are issued one per cycle with mem_rden=1.
REQ-026 rd_valid SHALL follow each STREAM read by exactly 2 cycles, with rd_index equal to the issued address; gaps are not allowed.
REQ-027 rd_last SHALL coincide with the rd_valid beat for address count; rd_done SHALL pulse in that same cycle.
REQ-028 If count=0, the controller SHALL skip STREAM, pulse rd_done at t+4 with no rd_valid and no rd_last, and return to IDLE.
REQ-029 If count>PARTICLE_NUM-1, the stream SHALL be clamped to PARTICLE_NUM-1 particles and cnt_err SHALL be set; cnt_err clears only on rst.
REQ-030 After the last STREAM issue, the FSM SHALL wait in DRAIN for 2 cycles and then return to IDLE; rd_busy drops in the cycle after rd_done.
REQ-031 A wr_req present during a stream SHALL wait; wr_ack SHALL never be asserted while rd_busy=1.
REQ-032 When a stream and a write are both pending on return to IDLE, the stream SHALL be served first.

Reset
REQ-033 While rst=1, and on the cycle after it, the FSM SHALL be in IDLE and all outputs SHALL be 0, including mem_address and mem_data; rd_pend, count and cnt_err SHALL be cleared.
REQ-034 A reset mid-stream SHALL abort the stream: in-flight mem_q data SHALL be discarded, with no rd_valid and no rd_done after reset.

Verification
REQ-035 Count word=3, rd_start at t -> mem_address 0 at t+1; addresses 1,2,3 at t+4..t+6; rd_valid at t+6..t+8 with rd_index 1,2,3; rd_last and rd_done at t+8.
REQ-036 Count word=0 -> rd_done at t+4; no rd_valid; rd_busy low at t+5.
REQ-037 Count word=250 with PARTICLE_NUM=220 -> 219 beats; last rd_index=219; cnt_err=1 until rst.
REQ-038 wr_req with wr_addr=5 and rd_start in the same IDLE cycle -> the full stream runs first; wr_ack with mem_wren=1 comes only after rd_done; read-back of address 5 returns wr_data.
REQ-039 Two rd_start pulses during a stream -> exactly one extra stream follows; the third request is dropped.
REQ-040 rst asserted during STREAM -> IDLE next cycle; rd_valid, rd_done and mem_rden all stay 0; a new rd_start then works normally.
